// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared FSM state type and default FIFO register addresses
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [31:0] DEF_WR_ADDR = 32'h1;
  localparam logic [31:0] DEF_RD_ADDR = 32'h2;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; last=1 means requester 1 won most recently
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/apb_fifo_arbiter.sv
// rtl/apb_fifo_arbiter.sv - two-requester APB master issuing push/pop transfers to a FIFO completer
module apb_fifo_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] WR_ADDR = DEF_WR_ADDR,
  parameter logic [31:0] RD_ADDR = DEF_RD_ADDR,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [31:0]       PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  state_t              r_state;
  logic                r_grant;
  logic                r_last;
  logic [31:0]         r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [TCW-1:0]      r_tcnt;

  logic [1:0]          w_arb_req;
  logic [1:0]          w_arb_grant;
  logic                w_sel;
  logic                w_sel_write;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_timeout;
  logic                w_complete;
  logic                w_load;
  logic                w_to_idle;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_err;

  // The requester just served is masked out so a completion can only hand over to the other one.
  assign w_arb_req = (r_state == ST_ACCESS)
                   ? ({req1_valid, req0_valid} & (r_grant ? 2'b01 : 2'b10))
                   : {req1_valid, req0_valid};

  rr_arbiter2 u_rr (
    .req   (w_arb_req),
    .last  (r_last),
    .grant (w_arb_grant)
  );

  assign w_sel       = w_arb_grant[1];
  assign w_sel_write = w_sel ? req1_write : req0_write;
  assign w_sel_wdata = w_sel ? req1_wdata : req0_wdata;

  assign w_timeout  = (r_state == ST_ACCESS) && !PREADY && (r_tcnt == TCW'(TIMEOUT - 1));
  assign w_complete = PRESET && (r_state == ST_ACCESS) && (PREADY || w_timeout);
  assign w_load     = (|w_arb_grant) && ((r_state == ST_IDLE) || w_complete);
  assign w_to_idle  = w_complete && !(|w_arb_grant);

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_tcnt  <= '0;
    end else if (w_load) begin
      r_state <= ST_SETUP;
      r_grant <= w_sel;
      r_last  <= w_sel;
      r_addr  <= w_sel_write ? WR_ADDR : RD_ADDR;
      r_write <= w_sel_write;
      r_wdata <= w_sel_write ? w_sel_wdata : '0;
      r_tcnt  <= '0;
    end else if (w_to_idle) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_tcnt  <= '0;
    end else if (r_state == ST_SETUP) begin
      r_state <= ST_ACCESS;
    end else if ((r_state == ST_ACCESS) && !PREADY) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign PSEL    = (r_state != ST_IDLE);
  assign PENABLE = (r_state == ST_ACCESS);
  assign PADDR   = r_addr;
  assign PWRITE  = r_write;
  assign PWDATA  = r_wdata;

  // A timeout abort reports an error with no data.
  assign w_rdata = PREADY ? PRDATA : '0;
  assign w_err   = PREADY ? PSLVERR : 1'b1;

  assign req0_done  = w_complete && !r_grant;
  assign req0_rdata = req0_done ? w_rdata : '0;
  assign req0_err   = req0_done && w_err;
  assign req1_done  = w_complete && r_grant;
  assign req1_rdata = req1_done ? w_rdata : '0;
  assign req1_err   = req1_done && w_err;

endmodule

// File: tb/tb_apb_fifo_arbiter.sv
// tb/tb_apb_fifo_arbiter.sv - scoreboard bench for apb_fifo_arbiter with a FIFO completer model
module tb_apb_fifo_arbiter;

  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b0;
  logic          req0_valid, req0_write, req0_done, req0_err;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_done, req1_err;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic [31:0]   PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;
  logic          PSLVERR = 1'b0;

  apb_fifo_arbiter #(.DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed { logic id; logic err; logic [DW-1:0] rdata; } exp_t;
  typedef struct packed { logic write; logic [DW-1:0] wdata; } cmd_t;

  exp_t          sb[$];
  cmd_t          q0[$];
  cmd_t          q1[$];
  logic [DW-1:0] slv_fifo[$];
  bit            slv_ready = 1'b1;
  bit            rst_pending = 1'b1;
  bit            last_done0, last_done1;
  int            done_cnt0, done_cnt1;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = (q0.size() != 0);
    req0_write = (q0.size() != 0) ? q0[0].write : 1'b0;
    req0_wdata = (q0.size() != 0) ? q0[0].wdata : '0;
    req1_valid = (q1.size() != 0);
    req1_write = (q1.size() != 0) ? q1[0].write : 1'b0;
    req1_wdata = (q1.size() != 0) ? q1[0].wdata : '0;
  endtask

  task automatic cycle();
    exp_t          e;
    logic          id;
    logic [DW-1:0] rd;
    logic          er;
    @(negedge PCLK);
    PRESET  = !rst_pending;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (PSEL === 1'b1 && PENABLE === 1'b1 && slv_ready) begin
      PREADY = 1'b1;
      if (!PWRITE) begin
        if (slv_fifo.size() == 0) PSLVERR = 1'b1;
        else PRDATA = slv_fifo[0];
      end
    end
    #1;
    last_done0 = (req0_done === 1'b1);
    last_done1 = (req1_done === 1'b1);
    if (last_done0 && last_done1) check("both_done", 1, 0);
    if (last_done0 || last_done1) begin
      id = last_done1;
      rd = id ? req1_rdata : req0_rdata;
      er = id ? req1_err : req0_err;
      if (id) begin
        done_cnt1++;
        check("idle_req0_outs", {req0_err, req0_rdata}, 0);
      end else begin
        done_cnt0++;
        check("idle_req1_outs", {req1_err, req1_rdata}, 0);
      end
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, id}, 64'hFF);
      end else begin
        e = sb.pop_front();
        check("done_id", id, e.id);
        check("done_err", er, e.err);
        check("done_rdata", rd, e.rdata);
      end
    end
    if (PSEL === 1'b1 && PENABLE === 1'b1 && PREADY && !PSLVERR) begin
      if (PWRITE) slv_fifo.push_back(PWDATA);
      else void'(slv_fifo.pop_front());
    end
    if (last_done0 && q0.size() != 0) void'(q0.pop_front());
    if (last_done1 && q1.size() != 0) void'(q1.pop_front());
    drive_reqs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drained", sb.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    bit prev0;
    int acc;
    drive_reqs();

    // reset state
    rst_pending = 1'b1;
    cycle();
    rst_pending = 1'b0;
    cycle();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_pwdata", PWDATA, 0);

    // single push: SETUP at cycle 1, ACCESS+done at cycle 2
    q0.push_back('{1'b1, 32'hA5A5_0001});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    drive_reqs();
    cycle();
    check("c1_psel", PSEL, 1);
    check("c1_penable", PENABLE, 0);
    check("c1_paddr", PADDR, 32'h1);
    check("c1_pwrite", PWRITE, 1);
    check("c1_pwdata", PWDATA, 32'hA5A5_0001);
    cycle();
    check("c2_penable", PENABLE, 1);
    check("c2_done", last_done0, 1);
    cycle();
    check("c3_psel", PSEL, 0);

    // simultaneous push/pop after reset: req0 first, req1 back-to-back
    rst_pending = 1'b1;
    cycle();
    rst_pending = 1'b0;
    cycle();
    q0.push_back('{1'b1, 32'hB0B0_0002});
    q1.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'hA5A5_0001});
    drive_reqs();
    prev0 = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      cycle();
      if (prev0) begin
        check("b2b_psel", PSEL, 1);
        check("b2b_penable", PENABLE, 0);
        check("b2b_paddr", PADDR, 32'h2);
        check("b2b_pwdata", PWDATA, 0);
      end
      prev0 = last_done0;
    end
    drain(10);

    // fairness: req0 pushes, req1 pops, both continuously valid
    done_cnt0 = 0;
    done_cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 32'hF000_0000 + i});
      q1.push_back('{1'b0, 32'h0});
      sb.push_back('{1'b0, 1'b0, 32'h0});
      sb.push_back('{1'b1, 1'b0, (i == 0) ? 32'hB0B0_0002 : 32'hF000_0000 + (i - 1)});
    end
    drive_reqs();
    drain(60);
    check("fair_cnt0", done_cnt0, 4);
    check("fair_cnt1", done_cnt1, 4);

    // slave error on pop from empty FIFO
    q1.push_back('{1'b0, 32'h0});
    q1.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'hF000_0003});
    sb.push_back('{1'b1, 1'b1, 32'h0});
    drive_reqs();
    drain(20);

    // timeout: completer never ready
    slv_ready = 1'b0;
    q0.push_back('{1'b1, 32'hDEAD_0005});
    sb.push_back('{1'b0, 1'b1, 32'h0});
    drive_reqs();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (PSEL === 1'b1 && PENABLE === 1'b1) acc++;
      if (last_done0) break;
    end
    check("to_done", last_done0, 1);
    check("to_access_cycles", acc, 16);
    cycle();
    check("to_psel_after", PSEL, 0);
    slv_ready = 1'b1;
    check("to_sb_empty", sb.size(), 0);

    // reset while in ACCESS with the completer ready: no done, then tie goes to req0
    slv_ready = 1'b0;
    q1.push_back('{1'b1, 32'h1111_0006});
    drive_reqs();
    cycle();
    cycle();
    check("rst_in_access", {PSEL, PENABLE}, 2'b11);
    q0.push_back('{1'b1, 32'h0000_0007});
    drive_reqs();
    slv_ready = 1'b1;
    rst_pending = 1'b1;
    cycle();
    check("rst_no_done", {last_done1, last_done0}, 0);
    rst_pending = 1'b0;
    cycle();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    cycle();
    check("rst_tie_paddr", PADDR, 32'h1);
    check("rst_tie_pwdata", PWDATA, 32'h0000_0007);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
